regfile_bank: RTL and testbench

//  Parametrised multi-write-port register file for the 5-stage datapath; generalises the fixed 16x16 file.
//  Two independent write ports (WB-stage and second-result writes) and two combinational read ports for ID.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_clear_seq.sv | 64 ++++++
 rtl/regfile_bank.sv | 108 ++++++++++
 tb/tb_regfile_bank.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the parametrised register file.
// No logic; latency and backpressure are not applicable.
// Holds the clear-sequencer state encoding and default width/depth values.
package regfile_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_t;

endpackage

// File: rtl/regfile_clear_seq.sv
// Bulk-clear sequencer: walks every register address once, emitting one zero-write per cycle.
// Latency: busy rises the cycle after clr_req; 2**ADDR_W cycles in CLEAR, then a one-cycle clr_done.
// Backpressure: clr_req is honoured only in IDLE; requests in CLEAR or DONE are dropped, not queued.
// Ports: clk, rst (async active-low), clr_req in; busy, clr_done (registered), clr_en, clr_addr out.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_done,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_addr
);

    clr_state_t        state;
    logic [ADDR_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            busy     <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    clr_done <= 1'b0;
                    if (clr_req) begin
                        state <= CLEAR;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    // Last address reached: leave without incrementing so the counter never wraps.
                    if (cnt == '1) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        clr_done <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    clr_done <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    clr_done <= 1'b0;
                end
            endcase
        end
    end

    assign clr_en   = (state == CLEAR);
    assign clr_addr = cnt;

endmodule

// File: rtl/regfile_bank.sv
// Two-write / two-read register file with same-cycle bypass, optional zero register and bulk clear.
// Latency: reads combinational; writes visible in storage after the next rising edge; conflict flag 1 cycle late.
// Backpressure: none; writes presented while a clear is running (busy or clr_done) are dropped.
// Ports: rd_addr1/2 -> rd_data1/2; we1/wa1/wd1 and we2/wa2/wd2 write ports (port 2 wins a tie);
//        clr_req -> busy/clr_done; wr_conflict pulse; mon_data = stored value of register MON_REG.
module regfile_bank
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int MON_REG  = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    input  logic              we2,
    input  logic [ADDR_W-1:0] wa2,
    input  logic [DATA_W-1:0] wd2,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_done,
    output logic              wr_conflict,
    output logic [DATA_W-1:0] mon_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];

    logic              clr_en;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_ok;
    logic              we1_eff;
    logic              we2_eff;

    regfile_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_done (clr_done),
        .clr_en   (clr_en),
        .clr_addr (clr_addr)
    );

    // Sequencer is idle exactly when neither busy (CLEAR) nor clr_done (DONE) is set.
    assign wr_ok = !busy && !clr_done;

    // Writes to the hardwired zero register are squashed here, so they neither
    // land in storage, bypass, nor raise the conflict flag.
    assign we1_eff = we1 && wr_ok && !((ZERO_REG != 0) && (wa1 == '0));
    assign we2_eff = we2 && wr_ok && !((ZERO_REG != 0) && (wa2 == '0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            wr_conflict <= 1'b0;
        end else begin
            if (clr_en) begin
                regs[clr_addr] <= '0;
            end else begin
                if (we1_eff) regs[wa1] <= wd1;
                // Later assignment gives port 2 priority on an address tie.
                if (we2_eff) regs[wa2] <= wd2;
            end
            wr_conflict <= we1_eff && we2_eff && (wa1 == wa2);
        end
    end

    always_comb begin
        rd_data1 = regs[rd_addr1];
        if (BYPASS != 0) begin
            if (we2_eff && (wa2 == rd_addr1)) begin
                rd_data1 = wd2;
            end else if (we1_eff && (wa1 == rd_addr1)) begin
                rd_data1 = wd1;
            end
        end
        if ((ZERO_REG != 0) && (rd_addr1 == '0)) rd_data1 = '0;
    end

    always_comb begin
        rd_data2 = regs[rd_addr2];
        if (BYPASS != 0) begin
            if (we2_eff && (wa2 == rd_addr2)) begin
                rd_data2 = wd2;
            end else if (we1_eff && (wa1 == rd_addr2)) begin
                rd_data2 = wd1;
            end
        end
        if ((ZERO_REG != 0) && (rd_addr2 == '0)) rd_data2 = '0;
    end

    assign mon_data = regs[ADDR_W'(MON_REG)];

endmodule

// File: tb/tb_regfile_bank.sv
module tb_regfile_bank;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // Instance A: default parameters (16x16, zero register, bypass).
    logic [3:0]  a_rd_addr1, a_rd_addr2, a_wa1, a_wa2;
    logic [15:0] a_rd_data1, a_rd_data2, a_wd1, a_wd2, a_mon_data;
    logic        a_we1, a_we2, a_clr_req, a_busy, a_clr_done, a_wr_conflict;

    // Instance B: 32x32, no zero register, no bypass.
    logic [4:0]  b_rd_addr1, b_rd_addr2, b_wa1, b_wa2;
    logic [31:0] b_rd_data1, b_rd_data2, b_wd1, b_wd2, b_mon_data;
    logic        b_we1, b_we2, b_clr_req, b_busy, b_clr_done, b_wr_conflict;

    regfile_bank u_dut_a (
        .clk(clk), .rst(rst),
        .rd_addr1(a_rd_addr1), .rd_addr2(a_rd_addr2),
        .rd_data1(a_rd_data1), .rd_data2(a_rd_data2),
        .we1(a_we1), .wa1(a_wa1), .wd1(a_wd1),
        .we2(a_we2), .wa2(a_wa2), .wd2(a_wd2),
        .clr_req(a_clr_req), .busy(a_busy), .clr_done(a_clr_done),
        .wr_conflict(a_wr_conflict), .mon_data(a_mon_data)
    );

    regfile_bank #(
        .DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0), .MON_REG(15)
    ) u_dut_b (
        .clk(clk), .rst(rst),
        .rd_addr1(b_rd_addr1), .rd_addr2(b_rd_addr2),
        .rd_data1(b_rd_data1), .rd_data2(b_rd_data2),
        .we1(b_we1), .wa1(b_wa1), .wd1(b_wd1),
        .we2(b_we2), .wa2(b_wa2), .wd2(b_wd2),
        .clr_req(b_clr_req), .busy(b_busy), .clr_done(b_clr_done),
        .wr_conflict(b_wr_conflict), .mon_data(b_mon_data)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int cnt;
    int pulses;

    initial begin
        a_rd_addr1 = '0; a_rd_addr2 = '0; a_we1 = 0; a_wa1 = '0; a_wd1 = '0;
        a_we2 = 0; a_wa2 = '0; a_wd2 = '0; a_clr_req = 0;
        b_rd_addr1 = '0; b_rd_addr2 = '0; b_we1 = 0; b_wa1 = '0; b_wd1 = '0;
        b_we2 = 0; b_wa2 = '0; b_wd2 = '0; b_clr_req = 0;

        #2 rst = 1'b0;
        step();
        step();
        rst = 1'b1;

        // Reset state
        for (int i = 0; i < 16; i++) begin
            a_rd_addr1 = 4'(i);
            a_rd_addr2 = 4'(15 - i);
            #1;
            check("rst_rd1", 32'(a_rd_data1), 32'h0);
            check("rst_rd2", 32'(a_rd_data2), 32'h0);
        end
        check("rst_busy", 32'(a_busy), 32'h0);
        check("rst_clr_done", 32'(a_clr_done), 32'h0);
        check("rst_conflict", 32'(a_wr_conflict), 32'h0);
        for (int i = 0; i < 32; i++) begin
            b_rd_addr1 = 5'(i);
            #1;
            check("b_rst_rd", b_rd_data1, 32'h0);
        end

        // Same-cycle bypass, then stored value
        step();
        a_we1 = 1; a_wa1 = 4'd3; a_wd1 = 16'hF08F; a_rd_addr1 = 4'd3; a_rd_addr2 = 4'd3;
        #1;
        check("byp_rd1", 32'(a_rd_data1), 32'h0000F08F);
        check("byp_rd2", 32'(a_rd_data2), 32'h0000F08F);
        step();
        a_we1 = 0;
        #1;
        check("stored_rd1", 32'(a_rd_data1), 32'h0000F08F);
        check("single_no_conflict", 32'(a_wr_conflict), 32'h0);

        // Same-address collision: port 2 wins
        a_we1 = 1; a_wa1 = 4'd5; a_wd1 = 16'h1111;
        a_we2 = 1; a_wa2 = 4'd5; a_wd2 = 16'h2222; a_rd_addr1 = 4'd5;
        #1;
        check("coll_byp", 32'(a_rd_data1), 32'h00002222);
        step();
        a_we1 = 0; a_we2 = 0;
        #1;
        check("coll_flag", 32'(a_wr_conflict), 32'h1);
        check("coll_data", 32'(a_rd_data1), 32'h00002222);
        step();
        check("coll_flag_clr", 32'(a_wr_conflict), 32'h0);

        // Different addresses on both ports
        a_we1 = 1; a_wa1 = 4'd6; a_wd1 = 16'h6666;
        a_we2 = 1; a_wa2 = 4'd7; a_wd2 = 16'h7777; a_rd_addr1 = 4'd6; a_rd_addr2 = 4'd7;
        #1;
        check("dual_byp1", 32'(a_rd_data1), 32'h00006666);
        check("dual_byp2", 32'(a_rd_data2), 32'h00007777);
        step();
        a_we1 = 0; a_we2 = 0;
        #1;
        check("dual_no_conflict", 32'(a_wr_conflict), 32'h0);
        check("dual_stored2", 32'(a_rd_data2), 32'h00007777);

        // Zero register: writes discarded, no conflict
        a_we1 = 1; a_wa1 = 4'd0; a_wd1 = 16'hBEEF;
        a_we2 = 1; a_wa2 = 4'd0; a_wd2 = 16'hCAFE; a_rd_addr1 = 4'd0;
        #1;
        check("zero_byp", 32'(a_rd_data1), 32'h0);
        step();
        a_we1 = 0; a_we2 = 0;
        #1;
        check("zero_rd", 32'(a_rd_data1), 32'h0);
        check("zero_no_conflict", 32'(a_wr_conflict), 32'h0);

        // Fill regs 1..15, then monitor register
        for (int i = 1; i < 16; i++) begin
            a_we1 = 1; a_wa1 = 4'(i); a_wd1 = 16'h0E00 | 16'(i);
            step();
        end
        a_we1 = 1; a_wa1 = 4'd15; a_wd1 = 16'hABCD;
        #1;
        check("mon_no_bypass", 32'(a_mon_data), 32'h00000E0F);
        step();
        a_we1 = 0; a_rd_addr1 = 4'd7;
        #1;
        check("mon_data", 32'(a_mon_data), 32'h0000ABCD);
        check("fill_rd7", 32'(a_rd_data1), 32'h00000E07);

        // Bulk clear with a same-cycle write that commits first
        step();
        a_clr_req = 1; a_we1 = 1; a_wa1 = 4'd2; a_wd1 = 16'h7777;
        step();
        a_clr_req = 0; a_we1 = 0; a_rd_addr1 = 4'd2;
        #1;
        check("clr_wr_commit", 32'(a_rd_data1), 32'h00007777);
        check("busy_start", 32'(a_busy), 32'h1);
        cnt = 0;
        while (a_busy && cnt < 100) begin
            cnt++;
            a_we1 = 1; a_wa1 = 4'd9; a_wd1 = 16'h5555;
            a_we2 = 1; a_wa2 = 4'd9; a_wd2 = 16'h6666;
            a_clr_req = (cnt == 4);
            if (cnt == 9) begin
                a_rd_addr1 = 4'd8; a_rd_addr2 = 4'd9;
                #1;
                check("partial_rd8", 32'(a_rd_data1), 32'h00000E08);
                check("busy_wr_dropped", 32'(a_rd_data2), 32'h00000E09);
                check("busy_no_conflict", 32'(a_wr_conflict), 32'h0);
                a_rd_addr1 = 4'd7;
                #1;
                check("partial_rd7", 32'(a_rd_data1), 32'h0);
            end
            step();
        end
        a_we2 = 0;
        a_we1 = 1; a_wa1 = 4'd9; a_wd1 = 16'h5555;
        a_clr_req = 1;
        a_rd_addr1 = 4'd9;
        #1;
        check("busy_cycles", cnt, 16);
        check("clr_done_pulse", 32'(a_clr_done), 32'h1);
        check("done_busy", 32'(a_busy), 32'h0);
        check("done_no_bypass", 32'(a_rd_data1), 32'h0);
        step();
        a_clr_req = 0; a_we1 = 0;
        #1;
        check("clr_done_end", 32'(a_clr_done), 32'h0);
        check("idle_busy", 32'(a_busy), 32'h0);
        step();
        check("done_req_ignored", 32'(a_busy), 32'h0);
        for (int i = 0; i < 16; i++) begin
            a_rd_addr1 = 4'(i);
            #1;
            check("clr_all", 32'(a_rd_data1), 32'h0);
        end
        check("clr_mon", 32'(a_mon_data), 32'h0);

        // Reset in the middle of a clear
        step();
        a_we1 = 1; a_wa1 = 4'd12; a_wd1 = 16'h0C0C;
        step();
        a_we1 = 0; a_rd_addr1 = 4'd12;
        #1;
        check("pre_rst_rd12", 32'(a_rd_data1), 32'h00000C0C);
        a_clr_req = 1;
        step();
        a_clr_req = 0;
        repeat (6) step();
        check("busy_before_rst", 32'(a_busy), 32'h1);
        rst = 1'b0;
        #1;
        check("abort_busy", 32'(a_busy), 32'h0);
        check("abort_clr_done", 32'(a_clr_done), 32'h0);
        check("abort_rd12", 32'(a_rd_data1), 32'h0);
        step();
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (a_clr_done) pulses++;
        end
        check("abort_no_done", pulses, 0);
        check("abort_idle", 32'(a_busy), 32'h0);

        // Instance B: no bypass
        b_we1 = 1; b_wa1 = 5'd3; b_wd1 = 32'hDEADBEEF; b_rd_addr1 = 5'd3;
        #1;
        check("b_no_bypass", b_rd_data1, 32'h0);
        step();
        b_we1 = 0;
        #1;
        check("b_stored", b_rd_data1, 32'hDEADBEEF);

        b_we1 = 1; b_wa1 = 5'd5; b_wd1 = 32'h11111111;
        b_we2 = 1; b_wa2 = 5'd5; b_wd2 = 32'h22222222; b_rd_addr1 = 5'd5;
        #1;
        check("b_coll_no_byp", b_rd_data1, 32'h0);
        step();
        b_we1 = 0; b_we2 = 0;
        #1;
        check("b_coll_flag", 32'(b_wr_conflict), 32'h1);
        check("b_coll_data", b_rd_data1, 32'h22222222);
        step();
        check("b_coll_flag_clr", 32'(b_wr_conflict), 32'h0);

        // Register 0 is ordinary when the zero register is disabled
        b_we1 = 1; b_wa1 = 5'd0; b_wd1 = 32'hCAFE0000; b_rd_addr1 = 5'd0;
        step();
        b_we1 = 0;
        #1;
        check("b_reg0", b_rd_data1, 32'hCAFE0000);
        b_we1 = 1; b_wa1 = 5'd0; b_wd1 = 32'h1;
        b_we2 = 1; b_wa2 = 5'd0; b_wd2 = 32'h2;
        step();
        b_we1 = 0; b_we2 = 0;
        #1;
        check("b_reg0_conflict", 32'(b_wr_conflict), 32'h1);
        check("b_reg0_port2", b_rd_data1, 32'h2);

        b_we1 = 1; b_wa1 = 5'd31; b_wd1 = 32'h31313131;
        b_we2 = 1; b_wa2 = 5'd15; b_wd2 = 32'h0F0F0F0F;
        step();
        b_we1 = 0; b_we2 = 0; b_rd_addr1 = 5'd31;
        #1;
        check("b_mon", b_mon_data, 32'h0F0F0F0F);
        check("b_rd31", b_rd_data1, 32'h31313131);

        // Instance B bulk clear: 32 cycles
        step();
        b_clr_req = 1;
        step();
        b_clr_req = 0;
        cnt = 0;
        while (b_busy && cnt < 200) begin
            cnt++;
            step();
        end
        check("b_busy_cycles", cnt, 32);
        check("b_clr_done", 32'(b_clr_done), 32'h1);
        step();
        check("b_clr_done_end", 32'(b_clr_done), 32'h0);
        for (int i = 0; i < 32; i++) begin
            b_rd_addr1 = 5'(i);
            #1;
            check("b_clr_all", b_rd_data1, 32'h0);
        end
        check("b_clr_mon", b_mon_data, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
